// File: rtl/id_fetch_queue_pkg.sv
// Shared constants for the IF->ID fetch queue: empty-queue output values
// and the width of one stored {PC, NPC, NNPC, Instruct} bundle.
package id_fetch_queue_pkg;

  localparam int DEF_PCW = 32;
  localparam int DEF_DW  = 32;

  localparam logic [31:0] ini_if_PC_in       = 32'hBFC0_0000;
  localparam logic [31:0] ini_if_NPC_in      = ini_if_PC_in + 32'd4;
  localparam logic [31:0] ini_if_NNPC_in     = ini_if_PC_in + 32'd8;
  localparam logic [31:0] ini_if_Instruct_in = 32'h0000_0000;

  localparam int BW = 3 * DEF_PCW + DEF_DW;

  function automatic int bundle_width(input int pcw, input int dw);
    return 3 * pcw + dw;
  endfunction

endpackage

// File: rtl/fq_ptr_ctrl.sv
// Read/write pointers, occupancy count and push/pop/flush arbitration for
// the fetch queue, including the delay-slot entry kept across a redirect.
module fq_ptr_ctrl
  import id_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int BYPASS = 0,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  input  logic          dec_ready,
  input  logic          flush,
  input  logic          keep_ds,
  output logic          allowin,
  output logic          q_valid,
  output logic          bypass_sel,
  output logic          wr_en,
  output logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] wr_ptr,
  output logic [CW-1:0] count
);

  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          rd_adv;
  logic          keep_ok;
  logic [PW-1:0] keep_idx;
  logic [PW-1:0] rd_nxt;
  logic [PW-1:0] wr_nxt;
  logic [CW-1:0] count_nxt;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign bypass_sel = (BYPASS != 0) && empty;

  // An empty queue only presents a bundle when bypassing, and never in a flush cycle.
  assign q_valid = !rst && (empty ? (bypass_sel && if_valid && !flush) : 1'b1);
  assign pop     = q_valid && dec_ready;
  assign allowin = !full || pop;
  assign push    = if_valid && allowin && !flush;

  // A bypassed bundle consumed in the same cycle never touches the array.
  assign wr_en  = push && !(bypass_sel && pop);
  assign rd_adv = pop && !bypass_sel;

  always_comb begin
    rd_nxt    = rd_ptr;
    wr_nxt    = wr_ptr;
    count_nxt = count;
    keep_idx  = rd_ptr + PW'(rd_adv);
    keep_ok   = rd_adv ? (count >= CW'(2)) : (count >= CW'(1));
    if (flush) begin
      if (keep_ds && keep_ok) begin
        rd_nxt    = keep_idx;
        wr_nxt    = keep_idx + PW'(1);
        count_nxt = CW'(1);
      end else begin
        rd_nxt    = wr_ptr;
        count_nxt = '0;
      end
    end else begin
      rd_nxt    = rd_ptr + PW'(rd_adv);
      wr_nxt    = wr_ptr + PW'(wr_en);
      count_nxt = count + CW'(wr_en) - CW'(rd_adv);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      count  <= count_nxt;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(rd_adv && empty));

endmodule

// File: rtl/id_fetch_queue.sv
// DEPTH-entry decoupling buffer between IF and decode, using the pipeline's
// valid/allowin handshake, with optional bypass and delay-slot-aware flush.
module id_fetch_queue
  import id_fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              DW       = 32,
  parameter int              PCW      = 32,
  parameter int              BYPASS   = 0,
  parameter logic [PCW-1:0]  INI_PC   = ini_if_PC_in,
  parameter logic [DW-1:0]   INI_INST = ini_if_Instruct_in,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_valid_in,
  output logic           id_allowin_out,
  input  logic [PCW-1:0] if_PC_in,
  input  logic [PCW-1:0] if_NPC_in,
  input  logic [PCW-1:0] if_NNPC_in,
  input  logic [DW-1:0]  if_Instruct_in,
  input  logic           dec_ready_in,
  input  logic           flush_in,
  input  logic           keep_ds_in,
  output logic           q_valid_out,
  output logic [PCW-1:0] q_PC_out,
  output logic [PCW-1:0] q_NPC_out,
  output logic [PCW-1:0] q_NNPC_out,
  output logic [DW-1:0]  q_Instruct_out,
  output logic [CW-1:0]  q_count_out
);

  localparam int QW = bundle_width(PCW, DW);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PCW-1:0] INI_NPC  = INI_PC + PCW'(4);
  localparam logic [PCW-1:0] INI_NNPC = INI_PC + PCW'(8);

  logic [QW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          wr_en;
  logic          bypass_sel;

  fq_ptr_ctrl #(
    .DEPTH  (DEPTH),
    .BYPASS (BYPASS)
  ) u_ptr_ctrl (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid_in),
    .dec_ready  (dec_ready_in),
    .flush      (flush_in),
    .keep_ds    (keep_ds_in),
    .allowin    (id_allowin_out),
    .q_valid    (q_valid_out),
    .bypass_sel (bypass_sel),
    .wr_en      (wr_en),
    .rd_ptr     (rd_ptr),
    .wr_ptr     (wr_ptr),
    .count      (count)
  );

  // Storage is deliberately left unreset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {if_PC_in, if_NPC_in, if_NNPC_in, if_Instruct_in};
    end
  end

  // An empty queue shows the reset-vector bundle rather than stale array contents.
  always_comb begin
    {q_PC_out, q_NPC_out, q_NNPC_out, q_Instruct_out} = {INI_PC, INI_NPC, INI_NNPC, INI_INST};
    if (count != '0) begin
      {q_PC_out, q_NPC_out, q_NNPC_out, q_Instruct_out} = mem[rd_ptr];
    end else if (bypass_sel && q_valid_out) begin
      {q_PC_out, q_NPC_out, q_NNPC_out, q_Instruct_out} =
        {if_PC_in, if_NPC_in, if_NNPC_in, if_Instruct_in};
    end
  end

  assign q_count_out = count;

endmodule

// File: tb/tb_id_fetch_queue.sv
// Self-checking bench for id_fetch_queue: a queue-based scoreboard models the
// non-bypass instance, a second instance exercises the bypass path.
module tb_id_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] INI_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_valid, a_rdy, a_fl, a_kds, a_alw, a_qv;
  logic [31:0] a_pc, a_npc, a_nnpc, a_inst, a_qpc, a_qnpc, a_qnnpc, a_qinst;
  logic [2:0]  a_cnt;

  logic        b_valid, b_rdy, b_fl, b_kds, b_alw, b_qv;
  logic [31:0] b_pc, b_npc, b_nnpc, b_inst, b_qpc, b_qnpc, b_qnnpc, b_qinst;
  logic [2:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb[$];
  logic [31:0] exp_head;
  logic        exp_valid;
  logic        exp_allow;

  id_fetch_queue #(.DEPTH(DEPTH), .BYPASS(0)) dut_a (
    .clk(clk), .rst(rst), .if_valid_in(a_valid), .id_allowin_out(a_alw),
    .if_PC_in(a_pc), .if_NPC_in(a_npc), .if_NNPC_in(a_nnpc), .if_Instruct_in(a_inst),
    .dec_ready_in(a_rdy), .flush_in(a_fl), .keep_ds_in(a_kds), .q_valid_out(a_qv),
    .q_PC_out(a_qpc), .q_NPC_out(a_qnpc), .q_NNPC_out(a_qnnpc), .q_Instruct_out(a_qinst),
    .q_count_out(a_cnt)
  );

  id_fetch_queue #(.DEPTH(DEPTH), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .if_valid_in(b_valid), .id_allowin_out(b_alw),
    .if_PC_in(b_pc), .if_NPC_in(b_npc), .if_NNPC_in(b_nnpc), .if_Instruct_in(b_inst),
    .dec_ready_in(b_rdy), .flush_in(b_fl), .keep_ds_in(b_kds), .q_valid_out(b_qv),
    .q_PC_out(b_qpc), .q_NPC_out(b_qnpc), .q_NNPC_out(b_qnnpc), .q_Instruct_out(b_qinst),
    .q_count_out(b_cnt)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hA5A5, pc[15:0]};
  endfunction

  // Drive one cycle on the non-bypass instance and advance the scoreboard model.
  task automatic drive_a(input logic v, input logic [31:0] pc, input logic rdy,
                         input logic fl, input logic kds);
    logic pop_e, push_e;
    @(negedge clk);
    a_valid = v; a_pc = pc; a_npc = pc + 32'd4; a_nnpc = pc + 32'd8; a_inst = inst_of(pc);
    a_rdy = rdy; a_fl = fl; a_kds = kds;
    #1;
    exp_valid = (sb.size() > 0);
    exp_head  = exp_valid ? sb[0] : INI_PC;
    pop_e     = exp_valid && rdy;
    exp_allow = (sb.size() < DEPTH) || pop_e;
    push_e    = v && exp_allow && !fl;
    if (pop_e) void'(sb.pop_front());
    if (fl) begin
      if (kds && sb.size() > 0) begin
        while (sb.size() > 1) void'(sb.pop_back());
      end else begin
        sb.delete();
      end
    end else if (push_e) begin
      sb.push_back(pc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 0; a_pc = 0; a_npc = 0; a_nnpc = 0; a_inst = 0; a_rdy = 0; a_fl = 0; a_kds = 0;
    b_valid = 1; b_pc = 32'h0000_0AA0; b_npc = 0; b_nnpc = 0; b_inst = 0; b_rdy = 1; b_fl = 0; b_kds = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (a_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", a_cnt); end
    checks++; if (a_qv !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", a_qv); end
    checks++; if (a_qpc !== INI_PC) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", a_qpc, INI_PC); end
    checks++; if (a_qnpc !== INI_PC + 32'd4) begin errors++; $display("[TB] FAIL reset_npc: got %h expected %h", a_qnpc, INI_PC + 32'd4); end
    checks++; if (a_qnnpc !== INI_PC + 32'd8) begin errors++; $display("[TB] FAIL reset_nnpc: got %h expected %h", a_qnnpc, INI_PC + 32'd8); end
    checks++; if (a_qinst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 0", a_qinst); end
    checks++; if (b_qv !== 1'b0) begin errors++; $display("[TB] FAIL reset_bypass_valid: got %b expected 0", b_qv); end
    @(negedge clk);
    rst = 1'b0;
    b_valid = 0; b_rdy = 0;
    sb.delete();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      checks++; if (a_alw !== exp_allow) begin errors++; $display("[TB] FAIL fill_allowin: got %b expected %b", a_alw, exp_allow); end
      @(posedge clk); #1;
      checks++; if (int'(a_cnt) !== i + 1) begin errors++; $display("[TB] FAIL fill_count: got %0d expected %0d", a_cnt, i + 1); end
      checks++; if (a_qpc !== 32'h100) begin errors++; $display("[TB] FAIL fill_head: got %h expected 100", a_qpc); end
    end
    drive_a(1'b1, 32'h1F0, 1'b0, 1'b0, 1'b0);
    checks++; if (a_alw !== 1'b0) begin errors++; $display("[TB] FAIL full_allowin: got %b expected 0", a_alw); end
    checks++; if (a_qv !== 1'b1) begin errors++; $display("[TB] FAIL full_valid: got %b expected 1", a_qv); end
    @(posedge clk); #1;
    checks++; if (int'(a_cnt) !== sb.size()) begin errors++; $display("[TB] FAIL full_count: got %0d expected %0d", a_cnt, sb.size()); end
  endtask

  task automatic test_full_push_pop();
    drive_a(1'b1, 32'h110, 1'b1, 1'b0, 1'b0);
    checks++; if (a_alw !== 1'b1) begin errors++; $display("[TB] FAIL fullpp_allowin: got %b expected 1", a_alw); end
    checks++; if (a_qpc !== 32'h100) begin errors++; $display("[TB] FAIL fullpp_popped: got %h expected 100", a_qpc); end
    @(posedge clk); #1;
    checks++; if (a_cnt !== 3'd4) begin errors++; $display("[TB] FAIL fullpp_count: got %0d expected 4", a_cnt); end
    checks++; if (a_qpc !== 32'h104) begin errors++; $display("[TB] FAIL fullpp_head: got %h expected 104", a_qpc); end
    checks++; if (a_qnnpc !== 32'h10C) begin errors++; $display("[TB] FAIL fullpp_nnpc: got %h expected 10c", a_qnnpc); end
  endtask

  task automatic drain_a(input string tag);
    for (int k = 0; k < 8 && sb.size() > 0; k++) begin
      drive_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      checks++; if (a_qpc !== exp_head) begin errors++; $display("[TB] FAIL %s_order: got %h expected %h", tag, a_qpc, exp_head); end
      checks++; if (a_qinst !== inst_of(exp_head)) begin errors++; $display("[TB] FAIL %s_inst: got %h expected %h", tag, a_qinst, inst_of(exp_head)); end
    end
    @(posedge clk); #1;
    checks++; if (a_cnt !== 3'd0) begin errors++; $display("[TB] FAIL %s_empty: got %0d expected 0", tag, a_cnt); end
  endtask

  task automatic test_flush();
    drain_a("drain");
    for (int i = 0; i < 3; i++) drive_a(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    drive_a(1'b1, 32'h3F0, 1'b1, 1'b1, 1'b1);
    checks++; if (a_qpc !== 32'h300) begin errors++; $display("[TB] FAIL flush_keep_popped: got %h expected 300", a_qpc); end
    @(posedge clk); #1;
    checks++; if (a_cnt !== 3'd1) begin errors++; $display("[TB] FAIL flush_keep_count: got %0d expected 1", a_cnt); end
    checks++; if (a_qpc !== 32'h304) begin errors++; $display("[TB] FAIL flush_keep_head: got %h expected 304", a_qpc); end
    drive_a(1'b1, 32'h310, 1'b0, 1'b0, 1'b0);
    drive_a(1'b1, 32'h314, 1'b0, 1'b0, 1'b0);
    drive_a(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++; if (a_cnt !== 3'd0) begin errors++; $display("[TB] FAIL flush_all_count: got %0d expected 0", a_cnt); end
    checks++; if (a_qv !== 1'b0) begin errors++; $display("[TB] FAIL flush_all_valid: got %b expected 0", a_qv); end
    checks++; if (a_qpc !== INI_PC) begin errors++; $display("[TB] FAIL flush_all_pc: got %h expected %h", a_qpc, INI_PC); end
    checks++; if (a_qnpc !== INI_PC + 32'd4) begin errors++; $display("[TB] FAIL flush_all_npc: got %h expected %h", a_qnpc, INI_PC + 32'd4); end
    checks++; if (a_qinst !== 32'h0) begin errors++; $display("[TB] FAIL flush_all_inst: got %h expected 0", a_qinst); end
    drive_a(1'b1, 32'h320, 1'b0, 1'b0, 1'b0);
    drive_a(1'b1, 32'h324, 1'b0, 1'b0, 1'b0);
    drive_a(1'b1, 32'h3F4, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++; if (a_cnt !== 3'd1) begin errors++; $display("[TB] FAIL flush_keep_nopop_count: got %0d expected 1", a_cnt); end
    checks++; if (a_qpc !== 32'h320) begin errors++; $display("[TB] FAIL flush_keep_nopop_head: got %h expected 320", a_qpc); end
    drive_a(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++; if (a_cnt !== 3'd0) begin errors++; $display("[TB] FAIL flush_keep_last_count: got %0d expected 0", a_cnt); end
    checks++; if (a_qv !== 1'b0) begin errors++; $display("[TB] FAIL flush_keep_last_valid: got %b expected 0", a_qv); end
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive_a(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    drive_a(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b1, 32'h508 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      checks++; if (a_qpc !== exp_head) begin errors++; $display("[TB] FAIL wrap_order: got %h expected %h", a_qpc, exp_head); end
      checks++; if (a_alw !== 1'b1) begin errors++; $display("[TB] FAIL wrap_allowin: got %b expected 1", a_alw); end
      @(posedge clk); #1;
      checks++; if (int'(a_cnt) !== sb.size() || a_cnt > 3'd4) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected %0d", a_cnt, sb.size()); end
    end
    drain_a("wrap_drain");
  endtask

  task automatic test_bypass();
    @(negedge clk);
    b_valid = 1; b_pc = 32'h200; b_npc = 32'h204; b_nnpc = 32'h208; b_inst = inst_of(32'h200); b_rdy = 1;
    #1;
    checks++; if (b_qv !== 1'b1) begin errors++; $display("[TB] FAIL bypass_valid: got %b expected 1", b_qv); end
    checks++; if (b_qpc !== 32'h200) begin errors++; $display("[TB] FAIL bypass_pc: got %h expected 200", b_qpc); end
    checks++; if (b_qinst !== inst_of(32'h200)) begin errors++; $display("[TB] FAIL bypass_inst: got %h expected %h", b_qinst, inst_of(32'h200)); end
    @(posedge clk); #1;
    checks++; if (b_cnt !== 3'd0) begin errors++; $display("[TB] FAIL bypass_count: got %0d expected 0", b_cnt); end
    @(negedge clk);
    b_pc = 32'h204; b_npc = 32'h208; b_nnpc = 32'h20C; b_inst = inst_of(32'h204); b_rdy = 0;
    #1;
    checks++; if (b_qpc !== 32'h204) begin errors++; $display("[TB] FAIL bypass_nopop_pc: got %h expected 204", b_qpc); end
    @(posedge clk); #1;
    b_valid = 0; b_pc = 32'h2FC; #1;
    checks++; if (b_cnt !== 3'd1) begin errors++; $display("[TB] FAIL bypass_stored_count: got %0d expected 1", b_cnt); end
    checks++; if (b_qpc !== 32'h204) begin errors++; $display("[TB] FAIL bypass_stored_head: got %h expected 204", b_qpc); end
    @(negedge clk);
    b_rdy = 1; #1;
    checks++; if (b_qv !== 1'b1) begin errors++; $display("[TB] FAIL bypass_drain_valid: got %b expected 1", b_qv); end
    @(posedge clk); #1;
    checks++; if (b_cnt !== 3'd0) begin errors++; $display("[TB] FAIL bypass_drain_count: got %0d expected 0", b_cnt); end
    @(negedge clk);
    b_valid = 1; b_pc = 32'h208; b_fl = 1; #1;
    checks++; if (b_qv !== 1'b0) begin errors++; $display("[TB] FAIL bypass_flush_valid: got %b expected 0", b_qv); end
    @(posedge clk); #1;
    checks++; if (b_cnt !== 3'd0) begin errors++; $display("[TB] FAIL bypass_flush_count: got %0d expected 0", b_cnt); end
    @(negedge clk);
    b_valid = 0; b_rdy = 0; b_fl = 0;
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) drive_a(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++; if (a_cnt !== 3'd3) begin errors++; $display("[TB] FAIL mid_prefill_count: got %0d expected 3", a_cnt); end
    rst = 1'b1; #1;
    sb.delete();
    checks++; if (a_qv !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", a_qv); end
    checks++; if (a_cnt !== 3'd0) begin errors++; $display("[TB] FAIL mid_reset_count: got %0d expected 0", a_cnt); end
    checks++; if (a_qpc !== INI_PC) begin errors++; $display("[TB] FAIL mid_reset_pc: got %h expected %h", a_qpc, INI_PC); end
    @(negedge clk);
    rst = 1'b0; a_valid = 0;
    drive_a(1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
    checks++; if (a_qv !== 1'b0) begin errors++; $display("[TB] FAIL mid_first_valid: got %b expected 0", a_qv); end
    @(posedge clk); #1;
    checks++; if (a_qv !== 1'b1) begin errors++; $display("[TB] FAIL mid_push_valid: got %b expected 1", a_qv); end
    checks++; if (a_qpc !== 32'h700) begin errors++; $display("[TB] FAIL mid_push_head: got %h expected 700", a_qpc); end
    checks++; if (a_cnt !== 3'd1) begin errors++; $display("[TB] FAIL mid_push_count: got %0d expected 1", a_cnt); end
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_push_pop();
    test_flush();
    test_back_to_back();
    test_bypass();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
